// File: rtl/pci_target_addr_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_addr_decoder_pkg
// Description : Shared constants and types for the PCI target address
//               decoder: command codes, FSM state encoding, DWORD step.
// Revision    : 1.0 - initial release
// ============================================================================
package pci_target_addr_decoder_pkg;

  // PCI bus commands claimed by this target
  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  // Local address step per completed data phase, in bytes
  localparam int unsigned DWORD_INC = 4;

  // Decoder FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    IGNORE = 2'd2
  } state_t;

  // True for the two memory commands this target responds to
  function automatic logic is_mem_cmd(input logic [3:0] cmd);
    return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pci_target_addr_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_addr_decoder_if
// Description : PCI-side bus signals (active-high) plus the decoded local
//               outputs. master = bus/backend side, slave = decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface pci_target_addr_decoder_if #(
  parameter int NUM_BARS = 2,
  parameter int LOCAL_AW = 5
) ();

  logic [31:0]         AD;
  logic [3:0]          C_BE;
  logic                FRAME;
  logic                IRDY;
  logic                TRDY;
  logic                ADDRESS_valid;
  logic [LOCAL_AW-1:0] localAddress;
  logic [NUM_BARS-1:0] BAR_hit;
  logic                IS_WRITE;
  logic                STOP_req;

  modport master (
    output AD, C_BE, FRAME, IRDY, TRDY,
    input  ADDRESS_valid, localAddress, BAR_hit, IS_WRITE, STOP_req
  );

  modport slave (
    input  AD, C_BE, FRAME, IRDY, TRDY,
    output ADDRESS_valid, localAddress, BAR_hit, IS_WRITE, STOP_req
  );

endinterface
`default_nettype wire

// File: rtl/pci_target_addr_decoder_bar_match.sv
`default_nettype none
// ============================================================================
// Module      : pci_bar_match
// Description : Combinational BAR comparator. Compares the upper address
//               bits against every base window, qualifies with a memory
//               command and priority-encodes to a one-hot hit (lowest index
//               wins when windows overlap).
// Revision    : 1.0 - initial release
// ============================================================================
module pci_bar_match
  import pci_target_addr_decoder_pkg::*;
#(
  parameter int                    NUM_BARS = 2,
  parameter int                    LOCAL_AW = 5,
  parameter logic [NUM_BARS*32-1:0] BAR_BASE = {32'h00000800, 32'h00000400}
) (
  input  logic [31:LOCAL_AW]   addr_hi,
  input  logic [3:0]           cmd,
  output logic [NUM_BARS-1:0]  hit_onehot,
  output logic                 hit
);

  logic [NUM_BARS-1:0] bar_match;

  // One comparator per window on the bits above the window size
  for (genvar i = 0; i < NUM_BARS; i++) begin : g_bar
    assign bar_match[i] = (addr_hi == BAR_BASE[32*i+LOCAL_AW +: 32-LOCAL_AW]);
  end

  // Priority encode: the lowest matching index claims the transaction
  always_comb begin
    hit_onehot = '0;
    hit        = 1'b0;
    if (is_mem_cmd(cmd)) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        if (bar_match[i] && !hit) begin
          hit_onehot[i] = 1'b1;
          hit           = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pci_target_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_addr_decoder
// Description : Registered PCI target address decoder with NUM_BARS memory
//               windows. Samples AD/C_BE on the address phase, claims hits,
//               and presents a local byte offset that advances one DWORD per
//               completed data phase.
//               Optional feature macro: PCI_ADDR_DEC_BURST_EN
//                 defined   - linear burst increment with window-end STOP_req
//                 undefined - fixed local address, STOP_req after the first
//                             transfer of every claimed transaction
// Revision    : 1.0 - initial release
// ============================================================================
module pci_target_addr_decoder
  import pci_target_addr_decoder_pkg::*;
#(
  parameter int                     NUM_BARS = 2,
  parameter int                     LOCAL_AW = 5,
  parameter logic [NUM_BARS*32-1:0] BAR_BASE = {32'h00000800, 32'h00000400}
) (
  input  logic                       CLK,
  input  logic                       RST,
  pci_target_addr_decoder_if.slave   bus
);

  state_t              state, state_n;
  logic                frame_q;
  logic                valid_q, valid_n;
  logic [LOCAL_AW-1:0] addr_q, addr_n;
  logic [NUM_BARS-1:0] hit_q, hit_n;
  logic                write_q, write_n;
  logic                stop_q, stop_n;

  logic                addr_phase;
  logic [NUM_BARS-1:0] match_onehot;
  logic                match_hit;

`ifdef PCI_ADDR_DEC_BURST_EN
  // Burst is disabled for a transaction whose start address is not DWORD aligned
  logic                no_burst_q, no_burst_n;
  logic [LOCAL_AW:0]   addr_sum;
  assign addr_sum = {1'b0, addr_q} + (LOCAL_AW+1)'(DWORD_INC);
`endif

  pci_bar_match #(
    .NUM_BARS (NUM_BARS),
    .LOCAL_AW (LOCAL_AW),
    .BAR_BASE (BAR_BASE)
  ) u_bar_match (
    .addr_hi    (bus.AD[31:LOCAL_AW]),
    .cmd        (bus.C_BE),
    .hit_onehot (match_onehot),
    .hit        (match_hit)
  );

  // Address phase is the FRAME rising edge seen while idle
  assign addr_phase = (state == IDLE) && bus.FRAME && !frame_q;

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      frame_q    <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      hit_q      <= '0;
      write_q    <= 1'b0;
      stop_q     <= 1'b0;
`ifdef PCI_ADDR_DEC_BURST_EN
      no_burst_q <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      frame_q    <= bus.FRAME;
      valid_q    <= valid_n;
      addr_q     <= addr_n;
      hit_q      <= hit_n;
      write_q    <= write_n;
      stop_q     <= stop_n;
`ifdef PCI_ADDR_DEC_BURST_EN
      no_burst_q <= no_burst_n;
`endif
    end
  end

  // Next-state and next-output decode; everything holds unless changed below
  always_comb begin
    state_n    = state;
    valid_n    = valid_q;
    addr_n     = addr_q;
    hit_n      = hit_q;
    write_n    = write_q;
    stop_n     = stop_q;
`ifdef PCI_ADDR_DEC_BURST_EN
    no_burst_n = no_burst_q;
`endif

    case (state)
      IDLE: begin
        if (addr_phase) begin
          if (match_hit) begin
            state_n    = DATA;
            valid_n    = 1'b1;
            addr_n     = bus.AD[LOCAL_AW-1:0];
            hit_n      = match_onehot;
            write_n    = bus.C_BE[0];
            stop_n     = 1'b0;
`ifdef PCI_ADDR_DEC_BURST_EN
            no_burst_n = (bus.AD[1:0] != 2'b00);
`endif
          end else begin
            state_n = IGNORE;
          end
        end
      end

      IGNORE: begin
        if (!bus.FRAME && !bus.IRDY) begin
          state_n = IDLE;
        end
      end

      DATA: begin
        if (bus.IRDY && bus.TRDY) begin
          if (!bus.FRAME) begin
            // Last data phase: release the claim
            state_n    = IDLE;
            valid_n    = 1'b0;
            addr_n     = '0;
            hit_n      = '0;
            write_n    = 1'b0;
            stop_n     = 1'b0;
`ifdef PCI_ADDR_DEC_BURST_EN
            no_burst_n = 1'b0;
`endif
          end else begin
`ifdef PCI_ADDR_DEC_BURST_EN
            // Once disconnect is requested the address is frozen
            if (stop_q || no_burst_q || addr_sum[LOCAL_AW]) begin
              stop_n = 1'b1;
            end else begin
              addr_n = addr_sum[LOCAL_AW-1:0];
            end
`else
            stop_n = 1'b1;
`endif
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.ADDRESS_valid = valid_q;
  assign bus.localAddress  = addr_q;
  assign bus.BAR_hit       = hit_q;
  assign bus.IS_WRITE      = write_q;
  assign bus.STOP_req      = stop_q;

endmodule
`default_nettype wire

// File: tb/tb_pci_target_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pci_target_addr_decoder
// Description : Self-checking bench for pci_target_addr_decoder with default
//               parameters. Expected outputs come from a transaction-level
//               model of the window/burst rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_target_addr_decoder;

  localparam int NUM_BARS = 2;
  localparam int LOCAL_AW = 5;
  localparam int WIN      = 1 << LOCAL_AW;
  localparam logic [31:0] BASES [NUM_BARS] = '{32'h00000400, 32'h00000800};
`ifdef PCI_ADDR_DEC_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pci_target_addr_decoder_if #(.NUM_BARS(NUM_BARS), .LOCAL_AW(LOCAL_AW)) bus ();

  pci_target_addr_decoder #(
    .NUM_BARS (NUM_BARS),
    .LOCAL_AW (LOCAL_AW),
    .BAR_BASE ({32'h00000800, 32'h00000400})
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Wait for the active edge, then settle before sampling/driving
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Packed view of all outputs: {valid, hit[1:0], addr[4:0], write, stop}
  function automatic logic [9:0] outs();
    return {bus.ADDRESS_valid, bus.BAR_hit, bus.localAddress, bus.IS_WRITE, bus.STOP_req};
  endfunction

  // One complete transaction with random wait states, checked every cycle.
  // nx transfers; if held, FRAME stays high on all of them and a final
  // FRAME-low transfer closes the transaction.
  task automatic test_transaction(input logic [31:0] addr, input logic [3:0] cmd,
                                  input int nx, input bit held, input string tag);
    int           hit_idx;
    int           off;
    int           kmax;
    int           k;
    int           eff;
    bit           claim;
    bit           last;
    logic [1:0]   oh;
    logic [4:0]   a5;
    logic [9:0]   exp;
    logic [9:0]   act;
    logic [1:0]   rw;

    // Model: window hit with lowest index first, only for memory commands
    hit_idx = -1;
    if (cmd == 4'b0110 || cmd == 4'b0111) begin
      for (int i = NUM_BARS - 1; i >= 0; i--) begin
        if ((addr / WIN) == (BASES[i] / WIN)) hit_idx = i;
      end
    end
    claim = (hit_idx >= 0);
    off   = int'(addr % WIN);
    // Number of DWORD steps that stay inside the window
    if (BURST_EN && (off % 4 == 0)) kmax = (WIN - 4 - off) / 4;
    else kmax = 0;
    oh = 2'b00;
    if (claim) oh = 2'(1 << hit_idx);

    bus.FRAME = 1'b0; bus.IRDY = 1'b0; bus.TRDY = 1'b0;
    tick();

    bus.AD = addr; bus.C_BE = cmd; bus.FRAME = 1'b1;
    tick();
    a5  = 5'(off);
    exp = claim ? {1'b1, oh, a5, cmd[0], 1'b0} : 10'd0;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s decode: got %b expected %b", tag, act, exp);
    end

    if (!claim) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        bus.IRDY = 1'($urandom); bus.AD = $urandom;
        tick();
        act = outs();
        checks++;
        if (act !== 10'd0) begin
          errors++;
          $display("FAIL %s ignore_hold: got %b expected %b", tag, act, 10'd0);
        end
      end
      // FRAME low but IRDY still high: must remain ignoring
      bus.FRAME = 1'b0; bus.IRDY = 1'b1;
      tick();
      // A FRAME rise here is not an address phase (not idle yet)
      bus.FRAME = 1'b1; bus.IRDY = 1'b0; bus.AD = 32'h00000400; bus.C_BE = 4'b0111;
      tick();
      act = outs();
      checks++;
      if (act !== 10'd0) begin
        errors++;
        $display("FAIL %s ignore_no_decode: got %b expected %b", tag, act, 10'd0);
      end
      bus.FRAME = 1'b0; bus.IRDY = 1'b0;
      tick();
      act = outs();
      checks++;
      if (act !== 10'd0) begin
        errors++;
        $display("FAIL %s ignore_exit: got %b expected %b", tag, act, 10'd0);
      end
      return;
    end

    k = 0;
    for (int x = 1; x <= nx + (held ? 1 : 0); x++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        rw = 2'($urandom_range(0, 2));
        bus.IRDY = rw[0]; bus.TRDY = rw[1]; bus.FRAME = 1'b1; bus.AD = $urandom;
        tick();
        act = outs();
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL %s wait_hold: got %b expected %b", tag, act, exp);
        end
      end
      last = (x == nx + (held ? 1 : 0));
      bus.IRDY = 1'b1; bus.TRDY = 1'b1; bus.FRAME = !last; bus.AD = $urandom;
      tick();
      if (last) begin
        exp = 10'd0;
      end else begin
        k++;
        eff = (k < kmax) ? k : kmax;
        a5  = 5'(off + 4 * eff);
        exp = {1'b1, oh, a5, cmd[0], (k > kmax)};
      end
      act = outs();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s xfer%0d: got %b expected %b", tag, x, act, exp);
      end
    end
    bus.FRAME = 1'b0; bus.IRDY = 1'b0; bus.TRDY = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] act;
    RST = 1'b1;
    tick();
    tick();
    act = outs();
    checks++;
    if (act !== 10'd0) begin
      errors++;
      $display("FAIL reset: got %b expected %b", act, 10'd0);
    end
    RST = 1'b0;
  endtask

  task automatic test_single();
    test_transaction(32'h00000400, 4'b0111, 1, 1'b0, "write_0x400");
    test_transaction(32'h00000408, 4'b0110, 1, 1'b0, "read_0x408");
  endtask

  task automatic test_miss();
    test_transaction(32'h00000000, 4'b0110, 1, 1'b0, "miss_addr");
    test_transaction(32'h00000400, 4'b0010, 1, 1'b0, "io_read");
    test_transaction(32'h00000400, 4'b0111, 1, 1'b0, "after_ignore");
  endtask

  task automatic test_burst();
    test_transaction(32'h00000804, 4'b0110, 3, 1'b0, "burst_0x804");
    test_transaction(32'h0000041C, 4'b0111, 3, 1'b1, "window_end");
    test_transaction(32'h00000812, 4'b0111, 3, 1'b1, "unaligned");
    test_transaction(32'h00000400, 4'b0110, 9, 1'b1, "full_window");
  endtask

  task automatic test_reset_mid_burst();
    logic [9:0] act;
    logic [9:0] exp;
    bus.FRAME = 1'b0; bus.IRDY = 1'b0; bus.TRDY = 1'b0;
    tick();
    bus.AD = 32'h00000804; bus.C_BE = 4'b0110; bus.FRAME = 1'b1;
    tick();
    bus.IRDY = 1'b1; bus.TRDY = 1'b1;
    tick();
    exp = BURST_EN ? {1'b1, 2'b10, 5'h08, 1'b0, 1'b0} : {1'b1, 2'b10, 5'h04, 1'b0, 1'b1};
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL rst_mid first_xfer: got %b expected %b", act, exp);
    end
    RST = 1'b1;
    tick();
    act = outs();
    checks++;
    if (act !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid clear: got %b expected %b", act, 10'd0);
    end
    RST = 1'b0; bus.FRAME = 1'b0; bus.IRDY = 1'b0; bus.TRDY = 1'b0;
    tick();
    bus.AD = 32'h00000400; bus.C_BE = 4'b0111; bus.FRAME = 1'b1;
    tick();
    exp = {1'b1, 2'b01, 5'h00, 1'b1, 1'b0};
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL rst_mid redecode: got %b expected %b", act, exp);
    end
    bus.IRDY = 1'b1; bus.TRDY = 1'b1; bus.FRAME = 1'b0;
    tick();
    act = outs();
    checks++;
    if (act !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid close: got %b expected %b", act, 10'd0);
    end
    bus.IRDY = 1'b0; bus.TRDY = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [3:0]  cmd;
    int          r;
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) r = r & ~3;
      case ($urandom_range(0, 4))
        0: addr = 32'h00000400 + 32'(r);
        1: addr = 32'h00000800 + 32'(r);
        2: addr = 32'h00000000 + 32'(r);
        3: addr = 32'h00000C00 + 32'(r);
        default: addr = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0, 1: cmd = 4'b0110;
        2, 3: cmd = 4'b0111;
        4: cmd = 4'b0010;
        default: cmd = 4'($urandom);
      endcase
      test_transaction(addr, cmd, int'($urandom_range(1, 9)), 1'($urandom), "random");
    end
  endtask

  initial begin
    bus.AD = '0; bus.C_BE = '0; bus.FRAME = 1'b0; bus.IRDY = 1'b0; bus.TRDY = 1'b0;
    test_reset();
    test_single();
    test_miss();
    test_burst();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
